stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent stopwatch channels (1..8).
REQ-002 Parameter PAUSE_TIMEOUT, default 1000: cycles in PAUSE before auto-return to IDLE; 0 disables the timeout.
REQ-003 clk  input  1  system clock; all state updates occur on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start_pulse  input  NUM_CH  per-channel one-cycle start/pause key pulse, already debounced.
REQ-006 lap_pulse  input  NUM_CH  per-channel one-cycle lap/reset key pulse, already debounced.
REQ-007 all_clear  input  1  synchronous global clear, one-cycle pulse.
REQ-008 count_en  output  NUM_CH  per-channel time-counter enable.
REQ-009 freeze  output  NUM_CH  per-channel display hold; the counter keeps running while set.
REQ-010 clear  output  NUM_CH  per-channel one-cycle counter-clear pulse.
REQ-011 state_o  output  2*NUM_CH  per-channel state code; channel i occupies bits [2i+1:2i].

Function
REQ-012 Each channel shall run an independent 4-state FSM with no coupling between channels except all_clear.
- State codes: IDLE=0, RUN=1, PAUSE=2, LAP=3.
REQ-013 IDLE transitions:
- start -> RUN.
- lap -> stay in IDLE and issue a clear pulse.
REQ-014 RUN transitions:
- start -> PAUSE.
- lap -> LAP.
REQ-015 PAUSE transitions:
- start -> RUN.
- lap -> IDLE and issue a clear pulse.
- timeout -> IDLE and issue a clear pulse.
REQ-016 LAP transitions:
- start -> PAUSE; freeze is released.
- lap -> RUN.
REQ-017 If start and lap arrive in the same cycle on one channel, start shall take effect and lap shall be ignored.
REQ-018 all_clear shall have highest priority: every channel goes to IDLE and issues a clear pulse, regardless of per-channel pulses in the same cycle.
REQ-019 count_en and freeze shall be Moore outputs decoded from the registered state.
- count_en = (state==RUN || state==LAP).
- freeze = (state==LAP).
- Both change in the cycle after the edge that samples the pulse.
REQ-020 clear shall be registered: high for exactly one cycle, coincident with the first cycle of the resulting IDLE state, i.e. one cycle after the causing pulse is sampled.
REQ-021 Each channel shall own a timeout counter of width $clog2(PAUSE_TIMEOUT+1), minimum 1 bit.
- Zeroed whenever the channel is not in PAUSE.
- Zeroed on any start or lap pulse.
- Otherwise increments each cycle the channel is in PAUSE.
REQ-022 Timeout timing: with no pulses, a channel whose state becomes PAUSE at cycle t shall show state IDLE at cycle t+PAUSE_TIMEOUT, with clear high in that cycle.
REQ-023 With PAUSE_TIMEOUT=0, PAUSE shall persist indefinitely; the counter shall be optimised away.
REQ-024 A pulse held high for k cycles shall be treated as k pulses; no edge detection is performed inside this block.

Reset
REQ-025 While rst_n is low, all channels shall be in IDLE, all timeout counters 0, and count_en, freeze and clear 0.
REQ-026 Assertion of rst_n mid-operation (RUN, PAUSE or LAP) shall force IDLE immediately and asynchronously, without issuing a clear pulse.
REQ-027 The first pulse sampled on the first rising edge after rst_n deasserts shall be honoured.

Structure
REQ-028 The state codes, and a localparam for the state width (2), shall live in package stopwatch_pkg, shared with the counter and display blocks.
REQ-029 Per-channel logic (FSM, timeout counter, clear register) shall be sub-module stopwatch_ch_fsm, instantiated NUM_CH times in a generate loop.
REQ-030 stopwatch_ctrl shall contain only instantiation, all_clear fan-out and output packing.

Verification
REQ-031 Reset then start_pulse[0] at cycle 5 -> state_o[1:0]=1 and count_en[0]=1 from cycle 6; channel 1 remains 0.
REQ-032 Channel 0 in RUN, then lap at cycle 10, lap at cycle 20 -> freeze[0]=1 for cycles 11..20; state RUN and freeze 0 at cycle 21; count_en[0] stays 1 throughout.
REQ-033 PAUSE_TIMEOUT=8: channel enters PAUSE at cycle t with no pulses -> state 0 and clear=1 at cycle t+8 only; start pulse at t+4 instead -> RUN at t+5 and no clear.
REQ-034 Both channels in RUN; start and lap together on channel 0 -> channel 0 goes to PAUSE, not LAP; channel 1 unaffected.
REQ-035 Channel 0 in LAP, channel 1 in PAUSE, all_clear together with start_pulse=2'b11 -> both channels in IDLE and clear=2'b11 for exactly one cycle.
REQ-036 rst_n pulled low asynchronously mid-cycle while channel 0 is in RUN -> count_en[0] drops before the next clock edge; no clear pulse after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: per-channel state encoding and its width.
// Used by the control, counter and display blocks.
package stopwatch_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_e;

endpackage

// File: rtl/stopwatch_ch_fsm.sv
// One stopwatch channel: start/lap FSM, pause timeout counter and registered
// clear pulse.
module stopwatch_ch_fsm
    import stopwatch_pkg::*;
#(
    parameter int PAUSE_TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               lap,
    input  logic               all_clear,
    output logic               count_en,
    output logic               freeze,
    output logic               clear,
    output logic [STATE_W-1:0] state_o
);

    sw_state_e state;
    sw_state_e state_nxt;
    logic      clear_nxt;
    logic      timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            clear <= 1'b0;
        end else begin
            state <= state_nxt;
            clear <= clear_nxt;
        end
    end

    // Start always wins over lap; all_clear overrides both.
    always_comb begin
        state_nxt = state;
        clear_nxt = 1'b0;
        if (all_clear) begin
            state_nxt = ST_IDLE;
            clear_nxt = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start)    state_nxt = ST_RUN;
                    else if (lap) clear_nxt = 1'b1;
                end
                ST_RUN: begin
                    if (start)    state_nxt = ST_PAUSE;
                    else if (lap) state_nxt = ST_LAP;
                end
                ST_PAUSE: begin
                    if (start) begin
                        state_nxt = ST_RUN;
                    end else if (lap || timeout) begin
                        state_nxt = ST_IDLE;
                        clear_nxt = 1'b1;
                    end
                end
                ST_LAP: begin
                    if (start)    state_nxt = ST_PAUSE;
                    else if (lap) state_nxt = ST_RUN;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    generate
        if (PAUSE_TIMEOUT > 0) begin : g_tmo
            localparam int CNT_W = $clog2(PAUSE_TIMEOUT + 1);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(PAUSE_TIMEOUT - 1);

            logic [CNT_W-1:0] cnt;

            // Staying in PAUSE implies no pulse and no expiry this cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt <= '0;
                else if (state == ST_PAUSE && state_nxt == ST_PAUSE)
                    cnt <= cnt + 1'b1;
                else
                    cnt <= '0;
            end

            assign timeout = (state == ST_PAUSE) && (cnt == LAST);
        end else begin : g_no_tmo
            assign timeout = 1'b0;
        end
    endgenerate

    assign count_en = (state == ST_RUN) || (state == ST_LAP);
    assign freeze   = (state == ST_LAP);
    assign state_o  = state;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Multi-channel stopwatch controller: NUM_CH independent channel FSMs sharing
// a global synchronous clear.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int PAUSE_TIMEOUT = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         start_pulse,
    input  logic [NUM_CH-1:0]         lap_pulse,
    input  logic                      all_clear,
    output logic [NUM_CH-1:0]         count_en,
    output logic [NUM_CH-1:0]         freeze,
    output logic [NUM_CH-1:0]         clear,
    output logic [STATE_W*NUM_CH-1:0] state_o
);

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            stopwatch_ch_fsm #(
                .PAUSE_TIMEOUT(PAUSE_TIMEOUT)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .start    (start_pulse[i]),
                .lap      (lap_pulse[i]),
                .all_clear(all_clear),
                .count_en (count_en[i]),
                .freeze   (freeze[i]),
                .clear    (clear[i]),
                .state_o  (state_o[STATE_W*i +: STATE_W])
            );
        end
    endgenerate

endmodule
